// File: rtl/fp16_align_stage.sv
// Binary16 adder pre-alignment stage: unpacks and orders two operands, flags
// infinities/NaNs and right-aligns the smaller significand with guard/round/sticky.
module fp16_align_stage #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int GRS_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+MANT_W:0]       A,
  input  logic [EXP_W+MANT_W:0]       B,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sign_big,
  output logic                        eff_sub,
  output logic [EXP_W-1:0]            exp_out,
  output logic [MANT_W+GRS_W:0]       mant_big,
  output logic [MANT_W+GRS_W:0]       mant_small,
  output logic [1:0]                  special,
  output logic                        special_sign
);

  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int SIG_W = MANT_W + 1;
  localparam int AL_W  = SIG_W + GRS_W;

  localparam logic [1:0] SPC_NORM = 2'b00;
  localparam logic [1:0] SPC_INF  = 2'b01;
  localparam logic [1:0] SPC_NAN  = 2'b10;

  logic              s1_valid, s2_valid;
  logic              adv1, adv2;

  logic              s1_sign_big, s1_eff_sub, s1_special_sign;
  logic [EXP_W-1:0]  s1_eexp, s1_diff;
  logic [SIG_W-1:0]  s1_sig_big, s1_sig_small;
  logic [1:0]        s1_special;

  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b, eexp_a, eexp_b;
  logic [MANT_W-1:0] frac_a, frac_b;
  logic [SIG_W-1:0]  sig_a, sig_b;
  logic              a_big, inf_a, inf_b, nan_a, nan_b;
  logic [1:0]        spc_c;
  logic              spc_sign_c;

  logic [AL_W-1:0]   ext, shifted, shift_mask, al_small;
  logic              sticky;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Unpack; denormals use an effective exponent of 1 and no hidden bit.
  always_comb begin
    sign_a = A[W-1];
    sign_b = B[W-1];
    exp_a  = A[W-2:MANT_W];
    exp_b  = B[W-2:MANT_W];
    frac_a = A[MANT_W-1:0];
    frac_b = B[MANT_W-1:0];
    eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
    sig_a  = {exp_a != '0, frac_a};
    sig_b  = {exp_b != '0, frac_b};
    a_big  = {eexp_a, sig_a} >= {eexp_b, sig_b};
    inf_a  = (exp_a == '1) && (frac_a == '0);
    inf_b  = (exp_b == '1) && (frac_b == '0);
    nan_a  = (exp_a == '1) && (frac_a != '0);
    nan_b  = (exp_b == '1) && (frac_b != '0);

    spc_c      = SPC_NORM;
    spc_sign_c = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      spc_c = SPC_NAN;
    end else if (inf_a) begin
      spc_c      = SPC_INF;
      spc_sign_c = sign_a;
    end else if (inf_b) begin
      spc_c      = SPC_INF;
      spc_sign_c = sign_b;
    end
  end

  // Alignment shift; anything shifted past the LSB folds into sticky.
  always_comb begin
    ext        = {s1_sig_small, {GRS_W{1'b0}}};
    shifted    = '0;
    shift_mask = '0;
    sticky     = 1'b0;
    if (s1_diff < EXP_W'(AL_W)) begin
      shifted    = ext >> s1_diff;
      shift_mask = (AL_W'(1) << s1_diff) - AL_W'(1);
      sticky     = |(ext & shift_mask);
    end else begin
      sticky     = |s1_sig_small;
    end
    al_small = {shifted[AL_W-1:1], shifted[0] | sticky};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid        <= 1'b0;
      s1_sign_big     <= 1'b0;
      s1_eff_sub      <= 1'b0;
      s1_eexp         <= '0;
      s1_sig_big      <= '0;
      s1_sig_small    <= '0;
      s1_diff         <= '0;
      s1_special      <= SPC_NORM;
      s1_special_sign <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign_big     <= a_big ? sign_a : sign_b;
        s1_eff_sub      <= sign_a ^ sign_b;
        s1_eexp         <= a_big ? eexp_a : eexp_b;
        s1_sig_big      <= a_big ? sig_a : sig_b;
        s1_sig_small    <= a_big ? sig_b : sig_a;
        s1_diff         <= a_big ? (eexp_a - eexp_b) : (eexp_b - eexp_a);
        s1_special      <= spc_c;
        s1_special_sign <= spc_sign_c;
      end
    end
  end

  // Output registers only load on advance, so a stalled result holds stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid     <= 1'b0;
      sign_big     <= 1'b0;
      eff_sub      <= 1'b0;
      exp_out      <= '0;
      mant_big     <= '0;
      mant_small   <= '0;
      special      <= SPC_NORM;
      special_sign <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sign_big     <= s1_sign_big;
        eff_sub      <= s1_eff_sub;
        exp_out      <= s1_eexp;
        mant_big     <= {s1_sig_big, {GRS_W{1'b0}}};
        mant_small   <= al_small;
        special      <= s1_special;
        special_sign <= s1_special_sign;
      end
    end
  end

endmodule

// File: doc/fp16_align_stage.md
Name: fp16_align_stage

Overview:
- Operand pre-alignment stage for the half-precision adder datapath; sits directly upstream of the add/normalise/round stage.
- Accepts two IEEE-754 binary16 operands over a valid/ready handshake.
- Unpacks both operands, orders them by magnitude and flags special cases.
- Right-shifts the smaller significand to the larger exponent, keeping guard, round and sticky bits, and presents the aligned pair downstream through a 2-stage stallable pipeline.

Parameters:
- MANT_W, 10, stored fraction width (binary16).
- EXP_W, 5, exponent width.
- GRS_W, 3, extra low-order bits (guard, round, sticky) on aligned significands.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept the pair this cycle.
- A  in  16  operand A, binary16.
- B  in  16  operand B, binary16.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts this cycle.
- sign_big  out  1  sign of the larger-magnitude operand.
- eff_sub  out  1  sign(A) XOR sign(B).
- exp_out  out  5  effective exponent of the larger operand.
- mant_big  out  14  {hidden, fraction, 3'b000}.
- mant_small  out  14  aligned smaller significand; LSB is sticky.
- special  out  2  00 normal, 01 infinity, 10 NaN.
- special_sign  out  1  sign of the infinity result; 0 when NaN.

Behaviour:
- Reset (rst low, async): s1_valid, s2_valid and out_valid go to 0; all data registers and outputs go to 0. Reset mid-transfer discards in-flight pairs; there is no partial output.
- Handshake: a pair is accepted on a clk edge when in_valid and in_ready are both high. Output is consumed when out_valid and out_ready are both high. While out_valid is high and out_ready is low, all outputs hold stable.
- Pipeline control:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1 (combinational, no dependence on in_valid)
  - Latency is 2 cycles from acceptance to out_valid. Throughput is 1 pair per cycle with no stall.
  - Order is preserved; no pair is dropped or duplicated.
- Stage 1 (unpack and compare):
  - eexp = (exp==0) ? 1 : exp.
  - sig = {exp!=0, fraction}, 11 bits.
  - Compare {eexp, sig} unsigned. The larger is "big"; on equality A is big.
  - diff = eexp_big - eexp_small, 5 bits, range 0..30.
  - Special detection, in priority order:
    - NaN if either exp==31 with fraction!=0, or both operands infinite with opposite signs.
    - Otherwise inf if either operand is infinite; special_sign is that infinity's sign.
  - Register: sign_big, eff_sub, eexp_big, sig_big, sig_small, diff, special, special_sign.
- Stage 2 (align):
  - mant_big = {sig_big, 3'b000}.
  - ext = {sig_small, 3'b000}.
  - If diff <= 13: shifted = ext >> diff; sticky = OR of the bits shifted out. If diff >= 14: shifted = 0; sticky = |sig_small.
  - mant_small = {shifted[13:1], shifted[0] | sticky}.
  - exp_out = eexp_big.
- Both operands zero: exp_out=1, mant_big=0, mant_small=0, special=00, sign_big=sign(A).
- Data outputs are don't-care-stable, but registered, when special != 00.

Test Plan:
- A=5620, B=5948, one pair with out_ready=1 -> out_valid exactly 2 cycles after acceptance; sign_big=0, eff_sub=0, exp_out=0x16, mant_big=0x2A40, mant_small=0x1880, special=00.
- A=5630, B=D590 (equal exponents, A larger) -> sign_big=0, eff_sub=1, exp_out=0x15, mant_big=0x3180, mant_small=0x2C80.
- A=3C00, B=0001 (diff=14) -> exp_out=0x0F, mant_big=0x2000, mant_small=0x0001 (sticky only); A=0000, B=0000 -> exp_out=01, both mantissas 0.
- A=7C00, B=FC00 -> special=10, special_sign=0. A=7C00, B=3C00 -> special=01, special_sign=0. A=7E00, B=3C00 -> special=10.
- Stall: drive 4 back-to-back pairs with out_ready=0 for 6 cycles -> in_ready low after 2 acceptances; outputs hold the first pair unchanged. Release out_ready -> 4 results in order, one per cycle, none lost.
- Assert rst low for 1 cycle with both stages full -> out_valid=0 and outputs 0 immediately; in_ready=1 after release; next pair emerges with 2-cycle latency.
